// File: rtl/tagged_pkg.sv
// Shared types and helpers for the tagged stream protocol blocks.
package tagged_pkg;

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } dist_state_t;

  // Width of a counter that indexes n tags; never narrower than one bit.
  function automatic int tag_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tagged_distributor_if.sv
// Stream interfaces: data_i carries untagged elements, tagged_i adds a
// routing tag consumed by per-tag multiplexers downstream.
interface data_i #(
  parameter type tuple_t = logic [15:0]
);
  tuple_t data;
  logic   keep;
  logic   last;
  logic   valid;
  logic   ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

interface tagged_i #(
  parameter type tuple_t   = logic [15:0],
  parameter int  TAG_WIDTH = 2
);
  tuple_t               data;
  logic                 keep;
  logic                 last;
  logic                 valid;
  logic [TAG_WIDTH-1:0] tag;
  logic                 ready;

  modport m (output data, keep, last, valid, tag, input ready);
  modport s (input data, keep, last, valid, tag, output ready);
endinterface

// File: rtl/tagged_output_register.sv
// Single-entry valid/ready register driving a tagged_i stream. A new value
// may be loaded whenever the slot is empty or is being consumed this cycle.
module tagged_output_register #(
  parameter type tuple_t   = logic [15:0],
  parameter int  TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  tuple_t               ld_data,
  input  logic                 ld_keep,
  input  logic                 ld_last,
  input  logic [TAG_WIDTH-1:0] ld_tag,
  output logic                 can_load,
  tagged_i.m                   out
);

  assign can_load = !out.valid || out.ready;

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values; combinational blocks elsewhere use blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.valid <= 1'b0;
      out.keep  <= 1'b0;
      out.last  <= 1'b0;
      out.tag   <= '0;
    end else if (can_load) begin
      out.valid <= load_en;
      if (load_en) begin
        out.keep <= ld_keep;
        out.last <= ld_last;
        out.tag  <= ld_tag;
      end
    end
  end

  // NOTE: the payload is deliberately left without reset; it is only
  // meaningful while out.valid is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (can_load && load_en) begin
      out.data <= ld_data;
    end
  end

endmodule

// File: rtl/tagged_distributor.sv
// Round-robin tag stamper with end-of-stream broadcast to every tag.
// Optional `TAGGED_DISTRIBUTOR_COUNT_EN adds the elem_count output.
module tagged_distributor
  import tagged_pkg::*;
#(
  parameter type tuple_t        = logic [15:0],
  parameter int  NUM_TAGS       = 4,
  parameter int  TAG_WIDTH      = 2,
  parameter bit  LAST_BROADCAST = 1'b1,
  parameter bit  FILTER_KEEP    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  data_i.s            in,
  tagged_i.m          out
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
  ,
  output logic [31:0] elem_count
`endif
);

  localparam int              RR_W     = tag_bits(NUM_TAGS);
  localparam bit              DO_FLUSH = LAST_BROADCAST && (NUM_TAGS > 1);
  localparam logic [RR_W-1:0] RR_MAX   = RR_W'(NUM_TAGS - 1);
  localparam logic [RR_W:0]   NT_EXT   = (RR_W + 1)'(NUM_TAGS);

  if (NUM_TAGS < 1 || NUM_TAGS > (1 << TAG_WIDTH)) begin : g_param_check
    $error("tagged_distributor: NUM_TAGS must be in 1..2**TAG_WIDTH");
  end

  dist_state_t          state;
  logic [RR_W-1:0]      rr;
  logic [RR_W-1:0]      ftag;
  logic [RR_W-1:0]      last_tag;
  logic                 last_tag_vld;

  logic                 can_load;
  logic                 in_fire;
  logic                 fwd;
  logic                 load_en;
  logic [RR_W:0]        fnext;
  logic                 flush_done;
  logic [RR_W-1:0]      fstart;
  tuple_t               ld_data;
  logic                 ld_keep;
  logic                 ld_last;
  logic [TAG_WIDTH-1:0] ld_tag;

  assign in.ready = can_load && (state == STREAM);
  assign in_fire  = in.valid && in.ready;
  assign fwd      = in_fire && (in.keep || !FILTER_KEEP);
  assign load_en  = (state == FLUSH) || fwd;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    ld_data = in.data;
    ld_keep = in.keep;
    ld_last = in.last;
    ld_tag  = TAG_WIDTH'(rr);
    if (state == FLUSH) begin
      ld_data = '0;
      ld_keep = 1'b0;
      ld_last = 1'b1;
      ld_tag  = TAG_WIDTH'(ftag);
    end

    // Next dummy tag, hopping over the tag that already carried the real
    // last so the flush never spends a cycle on a skipped tag.
    fnext = {1'b0, ftag} + 1'b1;
    if (last_tag_vld && (fnext == {1'b0, last_tag})) begin
      fnext = fnext + 1'b1;
    end
    flush_done = (fnext >= NT_EXT);

    fstart = (fwd && (rr == '0)) ? RR_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STREAM;
      rr           <= '0;
      ftag         <= '0;
      last_tag     <= '0;
      last_tag_vld <= 1'b0;
    end else begin
      case (state)
        STREAM: begin
          if (in_fire) begin
            if (in.last) begin
              rr <= '0;
              if (DO_FLUSH) begin
                state        <= FLUSH;
                ftag         <= fstart;
                last_tag     <= rr;
                last_tag_vld <= fwd;
              end
            end else if (fwd) begin
              rr <= (rr == RR_MAX) ? '0 : rr + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (can_load) begin
            if (flush_done) begin
              state <= STREAM;
            end else begin
              ftag <= fnext[RR_W-1:0];
            end
          end
        end
        default: state <= STREAM;
      endcase
    end
  end

  tagged_output_register #(
    .tuple_t   (tuple_t),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .ld_data  (ld_data),
    .ld_keep  (ld_keep),
    .ld_last  (ld_last),
    .ld_tag   (ld_tag),
    .can_load (can_load),
    .out      (out)
  );

`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
  // Counts delivered data elements only; flush dummies carry keep=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_count <= '0;
    end else if (out.valid && out.ready && out.keep) begin
      elem_count <= elem_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tagged_distributor.sv
// Bench for tagged_distributor: two configurations, directed and random
// streams, scored against a queue model built from the tagging rules.
`timescale 1ns/1ps
module tb_tagged_distributor;

  typedef logic [15:0] tuple_t;
  typedef struct packed {
    logic        dummy;
    logic [15:0] data;
    logic        keep;
    logic        last;
    logic [1:0]  tag;
  } exp_t;
  typedef exp_t exp_arr_t [0:4];

  localparam int A_TAGS  = 4;
  localparam bit A_BCAST = 1'b1;
  localparam bit A_FILT  = 1'b1;
  localparam int B_TAGS  = 3;
  localparam bit B_BCAST = 1'b0;
  localparam bit B_FILT  = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_i   #(.tuple_t(tuple_t))                 a_in ();
  tagged_i #(.tuple_t(tuple_t), .TAG_WIDTH(2))  a_out ();
  data_i   #(.tuple_t(tuple_t))                 b_in ();
  tagged_i #(.tuple_t(tuple_t), .TAG_WIDTH(2))  b_out ();

`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
  logic [31:0] a_elem_count;
  logic [31:0] b_elem_count;
`endif

  tagged_distributor #(
    .tuple_t(tuple_t), .NUM_TAGS(A_TAGS), .TAG_WIDTH(2),
    .LAST_BROADCAST(A_BCAST), .FILTER_KEEP(A_FILT)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .in  (a_in),
    .out (a_out)
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    ,
    .elem_count (a_elem_count)
`endif
  );

  tagged_distributor #(
    .tuple_t(tuple_t), .NUM_TAGS(B_TAGS), .TAG_WIDTH(2),
    .LAST_BROADCAST(B_BCAST), .FILTER_KEEP(B_FILT)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .in  (b_in),
    .out (b_out)
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    ,
    .elem_count (b_elem_count)
`endif
  );

  exp_t  a_q[$];
  exp_t  b_q[$];
  int    a_rr = 0;
  int    b_rr = 0;
  int    a_cnt_exp = 0;
  int    b_cnt_exp = 0;
  int    a_mode = 0;
  int    b_mode = 0;
  string a_tags = "";
  string a_flags = "";
  string b_tags = "";
  string b_flags = "";

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, got, exp);
    end
  endtask

  // Output sequence produced by one accepted input element.
  function automatic void model_step(input int n, input bit bcast, input bit filt, inout int rr,
                                     input logic [15:0] d, input logic k, input logic l,
                                     output exp_arr_t res, output int cnt);
    int real_tag;
    real_tag = -1;
    cnt = 0;
    for (int i = 0; i < 5; i++) res[i] = '0;
    if (k || !filt) begin
      res[cnt] = '{dummy: 1'b0, data: d, keep: k, last: l, tag: 2'(rr)};
      real_tag = rr;
      cnt++;
      rr = (rr + 1) % n;
    end
    if (l) begin
      if (bcast && n > 1) begin
        for (int t = 0; t < n; t++) begin
          if (t != real_tag) begin
            res[cnt] = '{dummy: 1'b1, data: 16'h0, keep: 1'b0, last: 1'b1, tag: 2'(t)};
            cnt++;
          end
        end
      end
      rr = 0;
    end
  endfunction

  function automatic logic [31:0] pack(input logic dummy, input logic [15:0] d, input logic k,
                                       input logic l, input logic [1:0] t);
    return {12'b0, dummy ? 16'h0 : d, k, l, t};
  endfunction

  function automatic string flag_of(input logic k, input logic l);
    if (k) return l ? "L" : "D";
    return l ? "x" : "d";
  endfunction

  // Scoreboard for DUT A: order, payload, and hold-while-stalled.
  initial begin : cmp_a
    logic        stall;
    logic [31:0] hold;
    logic [31:0] now_bits;
    exp_t        e;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      now_bits = {11'b0, a_out.data, a_out.keep, a_out.last, a_out.tag, a_out.valid};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) check("a_hold", now_bits, hold);
        if (a_out.valid && a_out.ready) begin
          a_tags  = {a_tags, $sformatf("%0d", a_out.tag)};
          a_flags = {a_flags, flag_of(a_out.keep, a_out.last)};
          if (a_q.size() == 0) begin
            check("a_extra_out", 32'(a_q.size()), 1);
          end else begin
            e = a_q.pop_front();
            check("a_out", pack(e.dummy, a_out.data, a_out.keep, a_out.last, a_out.tag),
                  pack(e.dummy, e.data, e.keep, e.last, e.tag));
            if (e.keep) a_cnt_exp++;
          end
        end
        stall = a_out.valid && !a_out.ready;
        hold  = now_bits;
      end
    end
  end

  initial begin : cmp_b
    logic        stall;
    logic [31:0] hold;
    logic [31:0] now_bits;
    exp_t        e;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      now_bits = {11'b0, b_out.data, b_out.keep, b_out.last, b_out.tag, b_out.valid};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) check("b_hold", now_bits, hold);
        if (b_out.valid && b_out.ready) begin
          b_tags  = {b_tags, $sformatf("%0d", b_out.tag)};
          b_flags = {b_flags, flag_of(b_out.keep, b_out.last)};
          if (b_q.size() == 0) begin
            check("b_extra_out", 32'(b_q.size()), 1);
          end else begin
            e = b_q.pop_front();
            check("b_out", pack(e.dummy, b_out.data, b_out.keep, b_out.last, b_out.tag),
                  pack(e.dummy, e.data, e.keep, e.last, e.tag));
            if (e.keep) b_cnt_exp++;
          end
        end
        stall = b_out.valid && !b_out.ready;
        hold  = now_bits;
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = toggle, other = random.
  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      case (a_mode)
        0:       a_out.ready = 1'b1;
        1:       a_out.ready = ~a_out.ready;
        default: a_out.ready = 1'($urandom_range(0, 1));
      endcase
      case (b_mode)
        0:       b_out.ready = 1'b1;
        1:       b_out.ready = ~b_out.ready;
        default: b_out.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_send(input logic [15:0] d, input logic k, input logic l);
    exp_arr_t r;
    int       n;
    int       guard;
    bit       done;
    guard = 0;
    done  = 1'b0;
    a_in.data = d; a_in.keep = k; a_in.last = l; a_in.valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (a_in.ready) begin
        model_step(A_TAGS, A_BCAST, A_FILT, a_rr, d, k, l, r, n);
        for (int i = 0; i < n; i++) a_q.push_back(r[i]);
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 200) begin
          check("a_accept_timeout", 32'(guard), 0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    a_in.valid = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] d, input logic k, input logic l);
    exp_arr_t r;
    int       n;
    int       guard;
    bit       done;
    guard = 0;
    done  = 1'b0;
    b_in.data = d; b_in.keep = k; b_in.last = l; b_in.valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (b_in.ready) begin
        model_step(B_TAGS, B_BCAST, B_FILT, b_rr, d, k, l, r, n);
        for (int i = 0; i < n; i++) b_q.push_back(r[i]);
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 200) begin
          check("b_accept_timeout", 32'(guard), 0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    b_in.valid = 1'b0;
  endtask

  task automatic a_stream(input int len, input int keep_pct, input int gap_max);
    for (int i = 0; i < len; i++) begin
      a_send(16'($urandom), 1'($urandom_range(0, 99) < keep_pct), 1'(i == len - 1));
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic b_stream(input int len, input int keep_pct, input int gap_max);
    for (int i = 0; i < len; i++) begin
      b_send(16'($urandom), 1'($urandom_range(0, 99) < keep_pct), 1'(i == len - 1));
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic a_drain();
    int g;
    g = 0;
    while (a_q.size() != 0 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("a_drain", 32'(a_q.size()), 0);
    idle(3);
  endtask

  task automatic b_drain();
    int g;
    g = 0;
    while (b_q.size() != 0 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("b_drain", 32'(b_q.size()), 0);
    idle(3);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    a_in.valid = 1'b0; a_in.data = '0; a_in.keep = 1'b0; a_in.last = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_in.keep = 1'b0; b_in.last = 1'b0;
    a_out.ready = 1'b1;
    b_out.ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_valid", 32'(a_out.valid), 0);
    check("rst_a_last",  32'(a_out.last), 0);
    check("rst_a_keep",  32'(a_out.keep), 0);
    check("rst_a_tag",   32'(a_out.tag), 0);
    check("rst_a_ready", 32'(a_in.ready), 1);
    check("rst_b_valid", 32'(b_out.valid), 0);
    check("rst_b_ready", 32'(b_in.ready), 1);
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    check("rst_a_count", a_elem_count, 0);
`endif
    @(posedge clk);
    #1;

    // Eight data elements, always ready.
    a_mode = 0; a_tags = ""; a_flags = "";
    for (int i = 0; i < 8; i++) a_send(16'(i * 17 + 3), 1'b1, 1'(i == 7));
    a_drain();
    check_str("a8_tags", a_tags, "01230123012");
    check_str("a8_flags", a_flags, "DDDDDDDLxxx");
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    check("a8_count", a_elem_count, 8);
`endif

    // Same stream with downstream ready toggling every cycle.
    a_mode = 1; a_tags = ""; a_flags = "";
    for (int i = 0; i < 8; i++) a_send(16'(16'hA000 + i), 1'b1, 1'(i == 7));
    a_drain();
    check_str("a8t_tags", a_tags, "01230123012");
    check_str("a8t_flags", a_flags, "DDDDDDDLxxx");

    // keep pattern 1,0,1,1: the dropped element does not advance the tag.
    a_mode = 0; a_tags = ""; a_flags = "";
    a_send(16'h1111, 1'b1, 1'b0);
    a_send(16'h2222, 1'b0, 1'b0);
    a_send(16'h3333, 1'b1, 1'b0);
    a_send(16'h4444, 1'b1, 1'b1);
    a_drain();
    check_str("akeep_tags", a_tags, "012013");
    check_str("akeep_flags", a_flags, "DDLxxx");

    // Lone dropped last: four dummies, input blocked for four load cycles.
    a_tags = ""; a_flags = "";
    a_send(16'h5555, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("aflush_ready_low", 32'(a_in.ready), 0);
    end
    @(negedge clk);
    check("aflush_ready_back", 32'(a_in.ready), 1);
    @(posedge clk);
    #1;
    a_drain();
    check_str("adrop_tags", a_tags, "0123");
    check_str("adrop_flags", a_flags, "xxxx");

    // Random streams under random backpressure.
    a_mode = 2;
    for (int s = 0; s < 10; s++) a_stream($urandom_range(1, 10), 70, 2);
    a_drain();
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    check("a_count_model", a_elem_count, 32'(a_cnt_exp));
`endif

    // Reset while a flush is in progress.
    a_mode = 0;
    a_send(16'h0A0A, 1'b1, 1'b0);
    a_send(16'h0B0B, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_q.delete(); b_q.delete();
    a_rr = 0; b_rr = 0; a_cnt_exp = 0; b_cnt_exp = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("amid_rst_valid", 32'(a_out.valid), 0);
    check("amid_rst_ready", 32'(a_in.ready), 1);
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    check("amid_rst_count", a_elem_count, 0);
`endif
    @(posedge clk);
    #1;
    a_tags = ""; a_flags = "";
    for (int i = 0; i < 5; i++) a_send(16'(16'h0C00 + i), 1'b1, 1'(i == 4));
    a_drain();
    check_str("apost_tags", a_tags, "01230123");

    // Config B: no broadcast, keep=0 forwarded, three tags.
    b_mode = 0; b_tags = ""; b_flags = "";
    for (int i = 0; i < 3; i++) b_send(16'(16'h0100 + i), 1'b1, 1'(i == 2));
    for (int i = 0; i < 3; i++) b_send(16'(16'h0200 + i), 1'b1, 1'(i == 2));
    for (int i = 0; i < 2; i++) b_send(16'(16'h0300 + i), 1'b1, 1'(i == 1));
    for (int i = 0; i < 2; i++) b_send(16'(16'h0400 + i), 1'b1, 1'(i == 1));
    b_drain();
    check_str("b_tags", b_tags, "0120120101");
    check_str("b_flags", b_flags, "DDLDDLDLDL");

    b_mode = 2;
    for (int s = 0; s < 10; s++) b_stream($urandom_range(1, 8), 50, 2);
    b_drain();
`ifdef TAGGED_DISTRIBUTOR_COUNT_EN
    check("b_count_model", b_elem_count, 32'(b_cnt_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
